// File: rtl/rotator_req_queue_if.sv
// rotator_req_queue_if
// Request/response bundle for the buffered rotate unit.
//   master : request producer / result consumer side
//   slave  : rotate queue side
// Signals:
//   req_val/req_rdy           request handshake
//   req_in_/req_amt/req_op    8-bit data, rotate amount 0..7, 0=left 1=right
//   resp_val/resp_rdy         result handshake
//   resp_out                  rotated result
//   count                     request-queue occupancy (output slot excluded)
interface rotator_req_queue_if #(
  parameter int CW = 3
);
  logic          req_val;
  logic          req_rdy;
  logic [7:0]    req_in_;
  logic [2:0]    req_amt;
  logic          req_op;
  logic          resp_val;
  logic          resp_rdy;
  logic [7:0]    resp_out;
  logic [CW-1:0] count;

  modport master (
    output req_val, req_in_, req_amt, req_op, resp_rdy,
    input  req_rdy, resp_val, resp_out, count
  );

  modport slave (
    input  req_val, req_in_, req_amt, req_op, resp_rdy,
    output req_rdy, resp_val, resp_out, count
  );
endinterface

// File: rtl/rotator_req_queue.sv
// rotator_req_queue
// In-order request queue in front of an 8-bit rotator. Requests are stored
// raw; the rotation is computed as the head entry moves into the registered
// output slot.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    rotator_req_queue_if.slave (request/response handshakes, count)
// Parameters:
//   DEPTH  queue entries, 1..4
//   CW     width of count, must hold 0..DEPTH
// Optional build macro:
//   ROTATOR_REQ_QUEUE_BYPASS_EN - a request arriving at an empty queue with a
//   free output slot is rotated straight into the slot (1-cycle latency).
module rotator_req_queue #(
  parameter int DEPTH = 2,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  rotator_req_queue_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic       op;
  } req_t;

  req_t          mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_rdy_q, req_rdy_d;
  logic          resp_val_q, resp_val_d;
  logic [7:0]    resp_out_q, resp_out_d;

  logic enq, slot_free, pop, push, byp;
  req_t req;

  // Rotate via a doubled word so amt=0 needs no special case.
  function automatic logic [7:0] rot(input req_t r);
    logic [15:0] t;
    if (!r.op) begin
      t   = {r.data, r.data} << r.amt;
      rot = t[15:8];
    end else begin
      t   = {r.data, r.data} >> r.amt;
      rot = t[7:0];
    end
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req       = '{data: bus.req_in_, amt: bus.req_amt, op: bus.req_op};
  assign enq       = bus.req_val && req_rdy_q;
  assign slot_free = !resp_val_q || bus.resp_rdy;
  assign pop       = (count_q != '0) && slot_free;

`ifdef ROTATOR_REQ_QUEUE_BYPASS_EN
  // Only when nothing is queued, so ordering is never disturbed.
  assign byp = enq && (count_q == '0) && slot_free;
`else
  assign byp = 1'b0;
`endif

  assign push = enq && !byp;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    resp_val_d = resp_val_q;
    resp_out_d = resp_out_q;
    if (push) tail_d = nxt(tail_q);
    if (pop) begin
      head_d     = nxt(head_q);
      resp_val_d = 1'b1;
      resp_out_d = rot(mem_q[head_q]);
    end else if (byp) begin
      resp_val_d = 1'b1;
      resp_out_d = rot(req);
    end else if (slot_free) begin
      resp_val_d = 1'b0;  // drain: data holds, only valid drops
    end
    count_d   = count_q + CW'(push) - CW'(pop);
    // Registered from next occupancy: no path from req_val/resp_rdy to req_rdy.
    req_rdy_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      resp_out_q <= 8'h00;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
      resp_out_q <= resp_out_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[tail_q] <= req;
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.resp_val = resp_val_q;
  assign bus.resp_out = resp_out_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_rotator_req_queue.sv
module tb_rotator_req_queue;
  localparam int DEPTH = 2;
`ifdef ROTATOR_REQ_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  rotator_req_queue_if #(.CW(3)) bus();
  rotator_req_queue #(.DEPTH(DEPTH), .CW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int enq_cyc[$];
  int deq_cyc[$];
  logic stall_prev = 0;
  logic [7:0] prev_out = 0;
  logic done = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gold(input logic [7:0] d, input int a, input logic o);
    logic [7:0] r;
    r = 0;
    for (int k = 0; k < 8; k++) begin
      if (!o) r[(k + a) % 8] = d[k];
      else    r[k] = d[(k + a) % 8];
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      chk("count_bound", {31'd0, bus.count <= 3'(DEPTH)}, 1);
      if (stall_prev) begin
        chk("stall_val", {31'd0, bus.resp_val}, 1);
        chk("stall_out", {24'd0, bus.resp_out}, {24'd0, prev_out});
      end
      if (bus.resp_val && bus.resp_rdy) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_resp: got %0h expected none", bus.resp_out);
        end else begin
          chk("resp_out", {24'd0, bus.resp_out}, {24'd0, sb.pop_front()});
          deq_cyc.push_back(cyc);
        end
      end
      stall_prev = bus.resp_val && !bus.resp_rdy;
      prev_out = bus.resp_out;
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic o, input logic [7:0] exp);
    logic ok;
    ok = 0;
    bus.req_val = 1; bus.req_in_ = d; bus.req_amt = a; bus.req_op = o;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.req_rdy) begin ok = 1; break; end
    end
    if (ok) begin
      sb.push_back(exp);
      enq_cyc.push_back(cyc);
      @(posedge clk); #1;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got req_rdy=0 expected acceptance");
    end
    bus.req_val = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [7:0] lt[8] = '{8'h5D, 8'hBA, 8'h75, 8'hEA, 8'hD5, 8'hAB, 8'h57, 8'hAE};
  logic [7:0] rt[8] = '{8'hD5, 8'hEA, 8'h75, 8'hBA, 8'h5D, 8'hAE, 8'h57, 8'hAB};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_val = 0; bus.req_in_ = 0; bus.req_amt = 0; bus.req_op = 0; bus.resp_rdy = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_resp_val", {31'd0, bus.resp_val}, 0);
    chk("rst_resp_out", {24'd0, bus.resp_out}, 0);
    chk("rst_count", {29'd0, bus.count}, 0);
    chk("rst_req_rdy", {31'd0, bus.req_rdy}, 1);
    @(posedge clk); #1;

    // Left rotations, back to back
    bus.resp_rdy = 1;
    enq_cyc.delete(); deq_cyc.delete();
    for (int i = 0; i < 8; i++) send(8'h5D, 3'(i), 1'b0, lt[i]);
    drain();
    chk("left_n", deq_cyc.size(), 8);
    if (deq_cyc.size() == 8 && enq_cyc.size() == 8) begin
      chk("left_latency", deq_cyc[0] - enq_cyc[0], LAT);
      chk("left_enq_b2b", enq_cyc[7] - enq_cyc[0], 7);
      chk("left_deq_b2b", deq_cyc[7] - deq_cyc[0], 7);
    end

    // Right rotations
    for (int i = 0; i < 8; i++) send(8'hD5, 3'(i), 1'b1, rt[i]);
    drain();

    // Backpressure: three accepted, fourth held off
    bus.resp_rdy = 0;
    send(8'h01, 3'd1, 1'b0, 8'h02);
    send(8'h02, 3'd1, 1'b0, 8'h04);
    send(8'h04, 3'd1, 1'b0, 8'h08);
    bus.req_val = 1; bus.req_in_ = 8'h08; bus.req_amt = 3'd1; bus.req_op = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_count", {29'd0, bus.count}, 2);
      chk("bp_req_rdy", {31'd0, bus.req_rdy}, 0);
      chk("bp_resp_out", {24'd0, bus.resp_out}, 8'h02);
      chk("bp_resp_val", {31'd0, bus.resp_val}, 1);
    end
    @(posedge clk); #1;
    bus.resp_rdy = 1;
    send(8'h08, 3'd1, 1'b0, 8'h10);
    drain();

    // Simultaneous enqueue and head transfer with count=1
    bus.resp_rdy = 0;
    send(8'h81, 3'd4, 1'b0, 8'h18);
    send(8'h0F, 3'd2, 1'b1, 8'hC3);
    @(negedge clk);
    chk("sim_count_pre", {29'd0, bus.count}, 1);
    @(posedge clk); #1;
    bus.resp_rdy = 1;
    send(8'hF0, 3'd3, 1'b0, 8'h87);
    @(negedge clk);
    chk("sim_count_post", {29'd0, bus.count}, 1);
    @(posedge clk); #1;
    drain();

    // Reset while full and stalled
    bus.resp_rdy = 0;
    send(8'h11, 3'd1, 1'b0, 8'h22);
    send(8'h22, 3'd1, 1'b0, 8'h44);
    send(8'h33, 3'd1, 1'b0, 8'h66);
    @(negedge clk);
    chk("full_count", {29'd0, bus.count}, 2);
    chk("full_resp_val", {31'd0, bus.resp_val}, 1);
    @(posedge clk); #1;
    reset = 1;
    sb.delete();
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mrst_resp_val", {31'd0, bus.resp_val}, 0);
    chk("mrst_resp_out", {24'd0, bus.resp_out}, 0);
    chk("mrst_count", {29'd0, bus.count}, 0);
    chk("mrst_req_rdy", {31'd0, bus.req_rdy}, 1);
    @(posedge clk); #1;
    bus.resp_rdy = 1;
    repeat (6) @(negedge clk);
    chk("mrst_quiet", {31'd0, bus.resp_val}, 0);
    @(posedge clk); #1;

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [7:0] d;
          logic [2:0] a;
          logic o;
          int idle;
          d = 8'($urandom_range(0, 255));
          a = 3'($urandom_range(0, 7));
          o = 1'($urandom_range(0, 1));
          idle = $urandom_range(0, 2);
          repeat (idle) begin @(posedge clk); #1; end
          send(d, a, o, gold(d, int'(a), o));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.resp_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.resp_rdy = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rotator_req_queue.md
Name: rotator_req_queue

Overview:
Buffered, sequential front-end for the 8-bit rotate datapath. It accepts rotate requests (data, amount, direction) over a val/rdy interface and holds them in a small in-order request queue. It computes each rotation when the request leaves the queue and presents the result from a registered output slot over a second val/rdy interface. It decouples the request producer from a result consumer that may stall.

Parameters:
DEPTH, 2, request-queue entries; legal values 1..4.
CW, 3, width of count output; must hold 0..DEPTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  queue can accept a request this cycle
req_in_  input  8  data to rotate
req_amt  input  3  rotate amount 0..7
req_op  input  1  0 = rotate left, 1 = rotate right
resp_val  output  1  output slot holds a result
resp_rdy  input  1  consumer accepts result this cycle
resp_out  output  8  rotated result
count  output  CW  current request-queue occupancy (output slot excluded)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: queue emptied, count=0, resp_val=0, resp_out=0x00, req_rdy=1 on the first cycle after reset. Reset overrides any same-cycle handshake. In-flight requests and results are discarded.
- Enqueue: fires when req_val && req_rdy. req_rdy = (count < DEPTH). req_rdy is registered state only and has no combinational path from resp_rdy or req_val.
- Dequeue: fires when resp_val && resp_rdy.
- Output slot is free when !resp_val || resp_rdy.
- Head transfer: if the queue is non-empty and the slot is free, at the clock edge:
  - the head entry pops;
  - resp_out <= rotate(head);
  - resp_val <= 1.
- Slot drain: if the slot is free and the queue is empty, resp_val <= 0 and resp_out holds its last value.
- Ordering: strictly FIFO; results emerge in request order with no drops or duplicates.
- Rotation:
  - op=0: out = (in_ << amt) | (in_ >> (8-amt));
  - op=1: out = (in_ >> amt) | (in_ << (8-amt));
  - amt=0 passes data unchanged.
  - All arithmetic is mod 8 bits. No sign behaviour.
- Latency (feature off): a request enqueued at edge E appears with resp_val=1 after edge E+1, if the slot is free at E+1.
- Throughput: one result per cycle sustained when resp_rdy=1.
- Simultaneous enqueue and head transfer in one cycle: count unchanged. Pointers wrap modulo DEPTH.
- Full: count==DEPTH drives req_rdy=0. req_val is ignored while req_rdy=0.
- Empty queue with resp_rdy=1 and no request: resp_val falls next cycle.
- Stall: while resp_val && !resp_rdy, resp_out and resp_val hold stable. The queue fills up to DEPTH.
- count next = count + enq − pop.

Optional Feature:
Macro ROTATOR_REQ_QUEUE_BYPASS_EN.
- Defined: if the queue is empty (count==0) and the slot is free, an enqueued request skips the queue. It writes rotate(req) into the output slot at the same edge E: 1-cycle latency, count stays 0.
- With the bypass, a request arriving while the queue is non-empty still enqueues, preserving order.
- Not defined: every request passes through the queue (2-cycle minimum latency).
- req_rdy timing and logic are identical in both builds.

Test Plan:
- Left rotate: in_=0x5D, op=0, amt=0..7, resp_rdy=1 -> results in order 0x5D,0xBA,0x75,0xEA,0xD5,0xAB,0x57,0xAE; back-to-back, one per cycle, resp_val first high 2 cycles after first enqueue (1 with bypass).
- Right rotate: in_=0xD5, op=1, amt=0..7 -> 0xD5,0xEA,0x75,0xBA,0x5D,0xAE,0x57,0xAB.
- Backpressure: resp_rdy=0, offer 4 requests (0x01 rotl1, 0x02 rotl1, 0x04 rotl1, 0x08 rotl1) -> 3 accepted, resp_out=0x02 held stable, count=2, req_rdy=0. Then resp_rdy=1 -> 0x02,0x04,0x08 in order, then the 4th (0x10).
- Simultaneous: count=1 and slot draining while a new request arrives -> count stays 1, no loss, order preserved.
- Reset mid-operation: queue full and resp_val=1, assert reset one cycle -> next cycle resp_val=0, resp_out=0x00, count=0, req_rdy=1; prior requests never emerge.
- Random: 200 random in_/amt/op with random req_val/resp_rdy -> every response matches the golden rotation in FIFO order; count never exceeds DEPTH.
